press_classifier: RTL and testbench

- Sits directly downstream of the push-button debouncer.
- Consumes its one-cycle press pulse and classifies each burst of presses as a single or double press within a programmable time window.
- Emits one-cycle pulses that drive the counter/display stages: for example, single increments the count and double performs an alternate action.
- Holds no data path beyond a window timer and an FSM.

---
 rtl/press_classifier_pkg.sv | 14 +
 rtl/press_classifier_window_timer.sv | 39 +++
 rtl/press_classifier.sv | 115 +++++++++++
 tb/tb_press_classifier.sv | 125 ++++++++++++
 4 files changed

// File: rtl/press_classifier_pkg.sv
// Shared constants and state encodings for the press classifier and its
// neighbouring button stages (debouncer shares the window timing constant).
package press_classifier_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT2 = 2'd1,
        WAIT3 = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WINDOW = 50_000_000;
    localparam int unsigned DEFAULT_TW     = 26;

endpackage

// File: rtl/press_classifier_window_timer.sv
// Second-press window timer: counts up from 0 while clr is low, saturates at
// WINDOW-1 and flags hit while parked there. clr forces 0 on the next edge.
module window_timer #(
    parameter int unsigned WINDOW = 8,
    parameter int unsigned TW     = 26
) (
    input  logic ck,
    input  logic reset,
    input  logic clr,
    output logic hit
);

    localparam logic [TW-1:0] LAST = TW'(WINDOW - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: clear, increment, or hold at the saturation value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = (count_q == LAST);

endmodule

// File: rtl/press_classifier.sv
// Classifies bursts of debounced press pulses as single/double (and triple,
// when built with TRIPLE_PRESS_EN) presses within a programmable window.
// All outputs are registered one-cycle pulses; busy follows the FSM state.
//
// state | meaning
// IDLE  | no press pending; timer held clear
// WAIT2 | one press seen, waiting for a second within the window
// WAIT3 | two presses seen, waiting for a third (TRIPLE_PRESS_EN only)
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int unsigned WINDOW = DEFAULT_WINDOW,
    parameter int unsigned TW     = DEFAULT_TW
) (
    input  logic ck,
    input  logic reset,
    input  logic press_in,
    output logic single_out,
    output logic double_out,
    output logic triple_out,
    output logic busy
);

    state_t state_q, state_d;
    logic   single_q, single_d;
    logic   double_q, double_d;
    logic   triple_q, triple_d;
    logic   busy_q, busy_d;
    logic   timer_clr;
    logic   timer_hit;

    window_timer #(
        .WINDOW (WINDOW),
        .TW     (TW)
    ) u_timer (
        .ck    (ck),
        .reset (reset),
        .clr   (timer_clr),
        .hit   (timer_hit)
    );

    // Next-state and output decode; a press always beats a timeout, and the
    // timer is cleared whenever the current window ends or restarts.
    always_comb begin
        state_d   = state_q;
        single_d  = 1'b0;
        double_d  = 1'b0;
        triple_d  = 1'b0;
        timer_clr = 1'b0;
        case (state_q)
            IDLE: begin
                timer_clr = 1'b1;
                if (press_in) begin
                    state_d = WAIT2;
                end
            end
            WAIT2: begin
                if (press_in) begin
                    timer_clr = 1'b1;
`ifdef TRIPLE_PRESS_EN
                    state_d   = WAIT3;
`else
                    double_d  = 1'b1;
                    state_d   = IDLE;
`endif
                end else if (timer_hit) begin
                    timer_clr = 1'b1;
                    single_d  = 1'b1;
                    state_d   = IDLE;
                end
            end
`ifdef TRIPLE_PRESS_EN
            WAIT3: begin
                if (press_in) begin
                    timer_clr = 1'b1;
                    triple_d  = 1'b1;
                    state_d   = IDLE;
                end else if (timer_hit) begin
                    timer_clr = 1'b1;
                    double_d  = 1'b1;
                    state_d   = IDLE;
                end
            end
`endif
            default: begin
                timer_clr = 1'b1;
                state_d   = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered output pulses.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            single_q <= 1'b0;
            double_q <= 1'b0;
            triple_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            double_q <= double_d;
            triple_q <= triple_d;
            busy_q   <= busy_d;
        end
    end

    assign single_out = single_q;
    assign double_out = double_q;
    assign triple_out = triple_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with WINDOW=8. Each vector is a press
// mask over cycles 0..NCYC-1 plus hand-computed per-cycle expected masks.
// Builds with or without TRIPLE_PRESS_EN.
module tb_press_classifier;

    localparam int unsigned WINDOW = 8;
    localparam int unsigned TW     = 4;
    localparam int          NCYC   = 24;

    logic ck = 1'b0;
    logic reset;
    logic press_in;
    logic single_out;
    logic double_out;
    logic triple_out;
    logic busy;

    int checks   = 0;
    int failures = 0;

    press_classifier #(
        .WINDOW (WINDOW),
        .TW     (TW)
    ) dut (
        .ck         (ck),
        .reset      (reset),
        .press_in   (press_in),
        .single_out (single_out),
        .double_out (double_out),
        .triple_out (triple_out),
        .busy       (busy)
    );

    always #5 ck = ~ck;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        press_in = 1'b0;
        @(negedge ck);
        reset = 1'b1;
        @(negedge ck);
        reset = 1'b0;
    endtask

    // Per-cycle observation packed as {triple, double, single, busy}.
    function automatic logic [3:0] obs_vec();
        return {triple_out, double_out, single_out, busy};
    endfunction

    task automatic run_seq(input string name, input logic [31:0] p, input logic [31:0] s,
                           input logic [31:0] d, input logic [31:0] t, input logic [31:0] b);
        logic [3:0] exp;
        do_reset();
        for (int c = 0; c < NCYC; c++) begin
            @(posedge ck);
            #1;
            exp = {t[c], d[c], s[c], b[c]};
            check_val($sformatf("%s c%0d", name, c), {28'd0, obs_vec()}, {28'd0, exp});
            press_in = p[c];
        end
        press_in = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        press_in = 1'b0;
        #12;
        check_val("reset_state", {28'd0, obs_vec()}, 32'd0);
        reset = 1'b0;

        // press 0 only: single at 9, busy 1..8
        run_seq("single", 32'h1, 32'h200, 32'h0, 32'h0, 32'h1FE);
        // presses 0 and 9: single at 9, new window gives single at 18
        run_seq("single_rearm", 32'h201, 32'h40200, 32'h0, 32'h0, 32'h3FDFE);
`ifndef TRIPLE_PRESS_EN
        // presses 0,3: double at 4
        run_seq("double_j2", 32'h9, 32'h0, 32'h10, 32'h0, 32'hE);
        // presses 0,8: last-slot second press, double at 9
        run_seq("double_j7", 32'h101, 32'h0, 32'h200, 32'h0, 32'h1FE);
        // presses 0..3: doubles at 2 and 4
        run_seq("b2b_pairs", 32'hF, 32'h0, 32'h14, 32'h0, 32'hA);
        // press held 0..5: doubles at 2, 4, 6
        run_seq("held", 32'h3F, 32'h0, 32'h54, 32'h0, 32'h2A);
`else
        // presses 0,2,4: triple at 5
        run_seq("triple", 32'h15, 32'h0, 32'h0, 32'h20, 32'h1E);
        // presses 0,2: double after full WAIT3 window, at 11
        run_seq("double_to", 32'h5, 32'h0, 32'h800, 32'h0, 32'h7FE);
        // presses 0,3: double at 12
        run_seq("double_to3", 32'h9, 32'h0, 32'h1000, 32'h0, 32'hFFE);
        // presses 0,1,2: triple at 3
        run_seq("triple_b2b", 32'h7, 32'h0, 32'h0, 32'h8, 32'h6);
`endif

        // press at 0, reset pulsed inside cycle 5: pending press discarded
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            @(posedge ck);
            #1;
            if (c == 5) begin
                check_val("pre_reset_busy", {28'd0, obs_vec()}, 32'h1);
                reset = 1'b1;
                #1;
                check_val("async_reset", {28'd0, obs_vec()}, 32'h0);
                #2;
                reset = 1'b0;
            end else if (c > 5) begin
                check_val($sformatf("post_reset c%0d", c), {28'd0, obs_vec()}, 32'h0);
            end
            press_in = (c == 0);
        end
        press_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
